// File: rtl/text_console_ctrl_if.sv
// CPU-side I/O register bus for the text console sequencer.
// The CPU drives address/data/strobes; the console returns registered read data.
interface text_console_ctrl_if;
    logic [7:0]  din;
    logic [11:0] address;
    logic        io_w_en;
    logic        io_r_en;
    logic [7:0]  dout;

    modport master (output din, address, io_w_en, io_r_en, input dout);
    modport slave  (input din, address, io_w_en, io_r_en, output dout);
endinterface

// File: rtl/text_console_ctrl.sv
// Terminal-style write sequencer for the GPU text RAM: cursor tracking,
// CR/LF/backspace handling, hardware scroll and full-screen clear.
module text_console_ctrl #(
    parameter int          COLS  = 80,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20,
    parameter logic [11:0] BASE  = 12'h081
) (
    input  logic                clk,
    input  logic                rst_n,
    text_console_ctrl_if.slave  io,
    output logic [11:0]         ram_w_addr,
    output logic [7:0]          ram_din,
    output logic                ram_w_en,
    output logic [11:0]         ram_r_addr,
    output logic                ram_r_en,
    input  logic [7:0]          ram_dout,
    output logic                busy
);

    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [11:0] ROWS_W    = 12'(ROWS);
    localparam logic [11:0] TOTAL     = 12'(COLS * ROWS);
    localparam logic [11:0] COPY_N    = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] ADDR_DATA = BASE;
    localparam logic [11:0] ADDR_CTRL = BASE + 12'd1;
    localparam logic [11:0] ADDR_COL  = BASE + 12'd2;
    localparam logic [11:0] ADDR_ROW  = BASE + 12'd3;

    typedef enum logic [2:0] {IDLE, PUT, SCROLL, SCROLL_CLR, CLEAR} state_t;

    state_t      state_reg, state_next;
    logic [11:0] col_reg, col_next;
    logic [11:0] row_reg, row_next;
    logic [11:0] cnt_reg, cnt_next;
    logic        scroll_pend_reg, scroll_pend_next;
    logic        overrun_reg, overrun_next;
    logic        w_en_reg, w_en_next;
    logic [11:0] w_addr_reg, w_addr_next;
    logic [7:0]  din_reg, din_next;
    logic        r_en_reg, r_en_next;
    logic [11:0] r_addr_reg, r_addr_next;
    logic        copy_reg, copy_next;
    logic [7:0]  dout_reg, dout_next;

    logic idle;
    logic wr_data, wr_ctrl, wr_col, wr_row;
    logic start_scroll;
    logic [7:0] ch;

    assign idle    = (state_reg == IDLE);
    assign ch      = io.din;
    assign wr_data = io.io_w_en && (io.address == ADDR_DATA);
    assign wr_ctrl = io.io_w_en && (io.address == ADDR_CTRL);
    assign wr_col  = io.io_w_en && (io.address == ADDR_COL);
    assign wr_row  = io.io_w_en && (io.address == ADDR_ROW);

    always_comb begin
        state_next       = state_reg;
        col_next         = col_reg;
        row_next         = row_reg;
        cnt_next         = cnt_reg;
        scroll_pend_next = scroll_pend_reg;
        overrun_next     = overrun_reg;
        w_en_next        = 1'b0;
        w_addr_next      = w_addr_reg;
        din_next         = din_reg;
        r_en_next        = 1'b0;
        r_addr_next      = r_addr_reg;
        copy_next        = 1'b0;
        dout_next        = dout_reg;
        start_scroll     = 1'b0;

        // Reads always observe the pre-write register values.
        if (io.io_r_en) begin
            if (io.address == ADDR_DATA)      dout_next = 8'h00;
            else if (io.address == ADDR_CTRL) dout_next = {6'b0, overrun_reg, !idle};
            else if (io.address == ADDR_COL)  dout_next = col_reg[7:0];
            else if (io.address == ADDR_ROW)  dout_next = row_reg[7:0];
        end

        // Clear first so a simultaneous set wins.
        if (wr_ctrl && io.din[1])
            overrun_next = 1'b0;
        if (!idle && (wr_data || wr_col || wr_row || (wr_ctrl && io.din[0])))
            overrun_next = 1'b1;

        unique case (state_reg)
            IDLE: begin
                if (wr_data) begin
                    if (ch >= 8'h20 && ch <= 8'h7E) begin
                        state_next  = PUT;
                        w_en_next   = 1'b1;
                        w_addr_next = row_reg * COLS_W + col_reg;
                        din_next    = ch;
                        if (col_reg == COLS_W - 12'd1) begin
                            col_next = 12'd0;
                            if (row_reg == ROWS_W - 12'd1) scroll_pend_next = 1'b1;
                            else                           row_next = row_reg + 12'd1;
                        end else begin
                            col_next = col_reg + 12'd1;
                        end
                    end else if (ch == 8'h0D) begin
                        col_next = 12'd0;
                    end else if (ch == 8'h0A) begin
                        col_next = 12'd0;
                        if (row_reg == ROWS_W - 12'd1) start_scroll = 1'b1;
                        else                           row_next = row_reg + 12'd1;
                    end else if (ch == 8'h08) begin
                        if (col_reg != 12'd0) begin
                            col_next = col_reg - 12'd1;
                        end else if (row_reg != 12'd0) begin
                            col_next = COLS_W - 12'd1;
                            row_next = row_reg - 12'd1;
                        end
                    end
                end else if (wr_ctrl && io.din[0]) begin
                    state_next  = CLEAR;
                    w_en_next   = 1'b1;
                    w_addr_next = 12'd0;
                    din_next    = BLANK;
                end else if (wr_col) begin
                    col_next = ({4'b0, io.din} > COLS_W - 12'd1) ? COLS_W - 12'd1 : {4'b0, io.din};
                end else if (wr_row) begin
                    row_next = ({4'b0, io.din} > ROWS_W - 12'd1) ? ROWS_W - 12'd1 : {4'b0, io.din};
                end
            end
            PUT: begin
                if (scroll_pend_reg) begin
                    scroll_pend_next = 1'b0;
                    start_scroll     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            SCROLL: begin
                // cnt_reg counts reads issued; the write trails its read by one cycle.
                if (cnt_reg == COPY_N) begin
                    state_next  = SCROLL_CLR;
                    w_en_next   = 1'b1;
                    w_addr_next = COPY_N;
                    din_next    = BLANK;
                end else begin
                    cnt_next    = cnt_reg + 12'd1;
                    r_en_next   = (cnt_reg + 12'd1) < COPY_N;
                    r_addr_next = COLS_W + cnt_reg + 12'd1;
                    w_en_next   = 1'b1;
                    w_addr_next = cnt_reg;
                    copy_next   = 1'b1;
                end
            end
            SCROLL_CLR, CLEAR: begin
                if (w_addr_reg == TOTAL - 12'd1) begin
                    state_next = IDLE;
                    if (state_reg == CLEAR) begin
                        col_next = 12'd0;
                        row_next = 12'd0;
                    end
                end else begin
                    w_en_next   = 1'b1;
                    w_addr_next = w_addr_reg + 12'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_scroll) begin
            state_next  = SCROLL;
            cnt_next    = 12'd0;
            r_en_next   = (COPY_N != 12'd0);
            r_addr_next = COLS_W;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            col_reg         <= 12'd0;
            row_reg         <= 12'd0;
            cnt_reg         <= 12'd0;
            scroll_pend_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            w_en_reg        <= 1'b0;
            w_addr_reg      <= 12'd0;
            din_reg         <= 8'h00;
            r_en_reg        <= 1'b0;
            r_addr_reg      <= 12'd0;
            copy_reg        <= 1'b0;
            dout_reg        <= 8'h00;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            row_reg         <= row_next;
            cnt_reg         <= cnt_next;
            scroll_pend_reg <= scroll_pend_next;
            overrun_reg     <= overrun_next;
            w_en_reg        <= w_en_next;
            w_addr_reg      <= w_addr_next;
            din_reg         <= din_next;
            r_en_reg        <= r_en_next;
            r_addr_reg      <= r_addr_next;
            copy_reg        <= copy_next;
            dout_reg        <= dout_next;
        end
    end

    // Copy writes forward the read data straight from the RAM's output register.
    assign ram_din    = copy_reg ? ram_dout : din_reg;
    assign ram_w_en   = w_en_reg;
    assign ram_w_addr = w_addr_reg;
    assign ram_r_en   = r_en_reg;
    assign ram_r_addr = r_addr_reg;
    assign busy       = !idle;
    assign io.dout    = dout_reg;

endmodule
